// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - PC control, instruction-memory fetch and decode handoff signals
interface fetch_sequencer_if;
    logic [31:0] pc;
    logic        pc_en;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ack;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic        trap_misaligned;
    logic        bus_error;

    // Sequencer side: drives PC control, fetch request and decode handoff
    modport master (
        input  pc, imem_ready, imem_rdata, instr_ack,
               redirect_valid, redirect_target, halt_req, resume,
        output pc_en, pc_src, pc_target, imem_req, imem_addr,
               instr, instr_pc, instr_valid, halted, trap_misaligned, bus_error
    );

    // Environment side: program counter, instruction memory and decode
    modport slave (
        output pc, imem_ready, imem_rdata, instr_ack,
               redirect_valid, redirect_target, halt_req, resume,
        input  pc_en, pc_src, pc_target, imem_req, imem_addr,
               instr, instr_pc, instr_valid, halted, trap_misaligned, bus_error
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch sequencer: boot delay, fetch/hold handshake, redirect, halt, traps
module fetch_sequencer #(
    parameter int BOOT_DELAY  = 2,
    parameter int MEM_TIMEOUT = 255
) (
    input logic              clk,
    input logic              reset,
    fetch_sequencer_if.master bus
);
    localparam int              BW        = $clog2(BOOT_DELAY + 1);
    localparam logic [BW-1:0]   BOOT_LAST = BW'(BOOT_DELAY - 1);
    localparam logic [7:0]      TMO_LAST  = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t         r_state;
    logic [BW-1:0]  r_boot_cnt;
    logic [7:0]     r_tmo;
    logic [31:0]    r_instr;
    logic [31:0]    r_instr_pc;
    logic           r_instr_valid;
    logic           r_halted;
    logic           r_trap;
    logic           r_bus_err;

    logic w_active;
    logic w_redirect;
    logic w_misaligned;
    logic w_take_redirect;
    logic w_fetch_done;

    // Redirect and halt are only honoured while fetching or holding an instruction
    assign w_active        = (r_state == S_FETCH) || (r_state == S_HOLD);
    assign w_redirect      = w_active && bus.redirect_valid;
    assign w_misaligned    = w_redirect && (bus.redirect_target[1:0] != 2'b00);
    assign w_take_redirect = w_redirect && !w_misaligned;
    // A completed fetch only advances the PC when nothing of higher priority is pending
    assign w_fetch_done    = (r_state == S_FETCH) && bus.imem_ready
                             && !bus.redirect_valid && !bus.halt_req;

    // Combinational outputs are forced low while reset is held
    assign bus.pc_en     = reset && (w_take_redirect || w_fetch_done);
    assign bus.pc_src    = reset && w_take_redirect;
    assign bus.imem_req  = reset && (r_state == S_FETCH);
    assign bus.imem_addr = reset ? bus.pc : 32'd0;
    assign bus.pc_target = reset ? bus.redirect_target : 32'd0;

    assign bus.instr           = r_instr;
    assign bus.instr_pc        = r_instr_pc;
    assign bus.instr_valid     = r_instr_valid;
    assign bus.halted          = r_halted;
    assign bus.trap_misaligned = r_trap;
    assign bus.bus_error       = r_bus_err;

    // Sequencer state machine with registered decode handoff and status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_BOOT;
            r_boot_cnt    <= '0;
            r_tmo         <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_trap        <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_trap    <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    if (r_boot_cnt == BOOT_LAST) begin
                        r_boot_cnt <= '0;
                        r_state    <= S_FETCH;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + BW'(1);
                    end
                end
                S_FETCH, S_HOLD: begin
                    if (w_misaligned) begin
                        r_trap        <= 1'b1;
                        r_instr_valid <= 1'b0;
                        r_halted      <= 1'b1;
                        r_tmo         <= '0;
                        r_state       <= S_HALT;
                    end else if (bus.halt_req) begin
                        r_instr_valid <= 1'b0;
                        r_halted      <= 1'b1;
                        r_tmo         <= '0;
                        r_state       <= S_HALT;
                    end else if (bus.redirect_valid) begin
                        // Flush the held instruction and restart fetching at the target
                        r_instr_valid <= 1'b0;
                        r_tmo         <= '0;
                        r_state       <= S_FETCH;
                    end else if (r_state == S_FETCH) begin
                        if (bus.imem_ready) begin
                            r_instr       <= bus.imem_rdata;
                            r_instr_pc    <= bus.pc;
                            r_instr_valid <= 1'b1;
                            r_tmo         <= '0;
                            r_state       <= S_HOLD;
                        end else if (r_tmo == TMO_LAST) begin
                            r_bus_err <= 1'b1;
                            r_halted  <= 1'b1;
                            r_tmo     <= '0;
                            r_state   <= S_HALT;
                        end else begin
                            r_tmo <= r_tmo + 8'd1;
                        end
                    end else if (bus.instr_ack) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (bus.resume) begin
                        r_halted <= 1'b0;
                        r_state  <= S_FETCH;
                    end
                end
                default: r_state <= S_BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n;

    fetch_sequencer_if bus();

    fetch_sequencer #(.BOOT_DELAY(2), .MEM_TIMEOUT(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter model: async clear, +4 or redirect when enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bus.pc <= 32'd0;
        else if (bus.pc_en)
            bus.pc <= bus.pc_src ? bus.pc_target : bus.pc + 32'd4;
    end

    // Instruction memory returns a word derived from its address
    assign bus.imem_rdata = bus.imem_addr ^ 32'hDEAD_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset                = 1'b0;
        bus.imem_ready       = 1'b1;
        bus.instr_ack        = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.redirect_target  = 32'h0;
        bus.halt_req         = 1'b0;
        bus.resume           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   bus.imem_req, 0);
        chk("rst_pc_en", bus.pc_en, 0);
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_berr",  bus.bus_error, 0);

        // Boot delay then streaming with ready and ack tied high
        reset = 1'b1;
        #1;
        chk("boot_req0", bus.imem_req, 0);
        tick();
        chk("boot_req1", bus.imem_req, 0);
        chk("boot_pc_en1", bus.pc_en, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("t1_req", bus.imem_req, 1);
            chk("t1_pc_en_fetch", bus.pc_en, 1);
            chk("t1_pc_src", bus.pc_src, 0);
            chk("t1_addr", bus.imem_addr, 32'(4 * k));
            tick();
            chk("t1_valid", bus.instr_valid, 1);
            chk("t1_instr_pc", bus.instr_pc, 32'(4 * k));
            chk("t1_instr", bus.instr, 32'(4 * k) ^ 32'hDEAD_0000);
            chk("t1_pc_en_hold", bus.pc_en, 0);
            if (k == 2) bus.imem_ready = 1'b0;
            tick();
        end

        // Slow fetch at 0x0C: ready after three stalled cycles
        bus.instr_ack = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("t2_req_stall", bus.imem_req, 1);
            chk("t2_pc_en_stall", bus.pc_en, 0);
            chk("t2_addr", bus.imem_addr, 32'h0C);
            chk("t2_valid_stall", bus.instr_valid, 0);
            tick();
        end
        bus.imem_ready = 1'b1;
        #1;
        chk("t2_req_ready", bus.imem_req, 1);
        chk("t2_pc_en_ready", bus.pc_en, 1);
        tick();
        chk("t2_valid", bus.instr_valid, 1);
        chk("t2_instr_pc", bus.instr_pc, 32'h0C);
        chk("t2_pc", bus.pc, 32'h10);
        chk("t2_req_hold", bus.imem_req, 0);
        tick();
        chk("t2_valid_stable", bus.instr_valid, 1);
        chk("t2_instr_pc_stable", bus.instr_pc, 32'h0C);

        // Aligned redirect while holding an instruction
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h170;
        #1;
        chk("t3_pc_en", bus.pc_en, 1);
        chk("t3_pc_src", bus.pc_src, 1);
        chk("t3_pc_target", bus.pc_target, 32'h170);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t3_flush", bus.instr_valid, 0);
        chk("t3_addr0", bus.imem_addr, 32'h170);
        chk("t3_pc_en_fetch", bus.pc_en, 1);
        tick();
        chk("t3_instr_pc", bus.instr_pc, 32'h170);
        chk("t3_pc_next", bus.pc, 32'h174);
        bus.instr_ack = 1'b1;
        tick();
        chk("t3_addr1", bus.imem_addr, 32'h174);
        bus.instr_ack = 1'b0;
        tick();
        chk("t3_instr_pc1", bus.instr_pc, 32'h174);
        chk("t3_pc_after", bus.pc, 32'h178);

        // Misaligned redirect traps and halts without moving the PC
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h172;
        #1;
        chk("t4_pc_en", bus.pc_en, 0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_trap", bus.trap_misaligned, 1);
        chk("t4_halted", bus.halted, 1);
        chk("t4_valid", bus.instr_valid, 0);
        chk("t4_pc", bus.pc, 32'h178);
        chk("t4_req", bus.imem_req, 0);
        bus.instr_ack = 1'b1;
        tick();
        chk("t4_trap_pulse", bus.trap_misaligned, 0);
        chk("t4_halted_stay", bus.halted, 1);
        chk("t4_ack_ignored", bus.instr_valid, 0);
        bus.instr_ack = 1'b0;

        // Fetch timeout: ready held low
        bus.imem_ready = 1'b0;
        bus.resume     = 1'b1;
        tick();
        bus.resume = 1'b0;
        #1;
        n = 0;
        while (bus.imem_req === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        chk("t5_req_cycles", 32'(n), 32'd255);
        chk("t5_bus_error", bus.bus_error, 1);
        chk("t5_halted", bus.halted, 1);
        tick();
        chk("t5_berr_pulse", bus.bus_error, 0);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        #1;
        chk("t5_resume_req", bus.imem_req, 1);
        chk("t5_resume_addr", bus.imem_addr, 32'h178);

        // Asynchronous reset in the middle of a fetch
        bus.imem_ready = 1'b1;
        #1;
        chk("t6_pc_en_pre", bus.pc_en, 1);
        reset = 1'b0;
        #1;
        chk("t6_pc_en", bus.pc_en, 0);
        chk("t6_req", bus.imem_req, 0);
        chk("t6_addr", bus.imem_addr, 0);
        chk("t6_pc_target", bus.pc_target, 0);
        chk("t6_instr", bus.instr, 0);
        chk("t6_instr_pc", bus.instr_pc, 0);
        chk("t6_valid", bus.instr_valid, 0);

        // Halt combined with an aligned redirect, then resume at the target
        tick();
        reset               = 1'b1;
        bus.redirect_target = 32'h200;
        tick();
        tick();
        chk("t7_req", bus.imem_req, 1);
        chk("t7_addr0", bus.imem_addr, 32'h0);
        tick();
        chk("t7_instr_pc", bus.instr_pc, 32'h0);
        bus.halt_req       = 1'b1;
        bus.redirect_valid = 1'b1;
        #1;
        chk("t7_pc_en", bus.pc_en, 1);
        chk("t7_pc_src", bus.pc_src, 1);
        tick();
        bus.halt_req       = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        chk("t7_halted", bus.halted, 1);
        chk("t7_valid", bus.instr_valid, 0);
        chk("t7_pc", bus.pc, 32'h200);
        chk("t7_req_halt", bus.imem_req, 0);
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        #1;
        chk("t7_resume_req", bus.imem_req, 1);
        chk("t7_resume_addr", bus.imem_addr, 32'h200);
        chk("t7_resume_pc_en", bus.pc_en, 1);
        tick();
        chk("t7_resume_instr_pc", bus.instr_pc, 32'h200);
        bus.instr_ack = 1'b1;
        tick();
        chk("t8_addr", bus.imem_addr, 32'h204);
        bus.instr_ack = 1'b0;
        bus.halt_req  = 1'b1;
        #1;
        chk("t8_pc_en", bus.pc_en, 0);
        chk("t8_req", bus.imem_req, 1);
        tick();
        bus.halt_req = 1'b0;
        #1;
        chk("t8_halted", bus.halted, 1);
        chk("t8_valid", bus.instr_valid, 0);
        chk("t8_pc", bus.pc, 32'h204);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
